// File: rtl/inv_sub_bytes_seq_pkg.sv
// aes_pkg: shared AES byte type, engine FSM states and lane/group sizing helpers
package aes_pkg;
  localparam int AES_NUM_BYTES = 16;
  typedef logic [7:0] byte_t;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;
  function automatic int groups(input int lanes);
    return AES_NUM_BYTES / lanes;
  endfunction
  function automatic int cnt_w(input int lanes);
    return (groups(lanes) > 1) ? $clog2(groups(lanes)) : 1;
  endfunction
endpackage

// File: rtl/inv_sub_bytes_seq_if.sv
// inv_sub_bytes_seq_if: input/output valid-ready bus of the SubBytes engine; adds mode under INV_SUB_BYTES_FWD_EN
interface inv_sub_bytes_seq_if;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_data;
`ifdef INV_SUB_BYTES_FWD_EN
  logic         mode;
  modport master (output in_valid, in_data, mode, out_ready, input in_ready, out_valid, out_data);
  modport slave (input in_valid, in_data, mode, out_ready, output in_ready, out_valid, out_data);
`else
  modport master (output in_valid, in_data, out_ready, input in_ready, out_valid, out_data);
  modport slave (input in_valid, in_data, out_ready, output in_ready, out_valid, out_data);
`endif
endinterface

// File: rtl/inv_sub_bytes_seq_inv_sbox.sv
// inv_sbox: combinational AES inverse S-box; forward table and per-lane mux under INV_SUB_BYTES_FWD_EN
module inv_sbox import aes_pkg::*; (
  input  byte_t a_i,
`ifdef INV_SUB_BYTES_FWD_EN
  input  logic  fwd_i,
`endif
  output byte_t y_o
);
  // each row holds 16 entries for one high nibble, entry 0 in the top byte
  logic [127:0] inv_row;
  always_comb begin
    case (a_i[7:4])
      4'h0: inv_row = 128'h52096ad53036a538bf40a39e81f3d7fb;
      4'h1: inv_row = 128'h7ce339829b2fff87348e4344c4dee9cb;
      4'h2: inv_row = 128'h547b9432a6c2233dee4c950b42fac34e;
      4'h3: inv_row = 128'h082ea16628d924b2765ba2496d8bd125;
      4'h4: inv_row = 128'h72f8f66486689816d4a45ccc5d65b692;
      4'h5: inv_row = 128'h6c704850fdedb9da5e154657a78d9d84;
      4'h6: inv_row = 128'h90d8ab008cbcd30af7e45805b8b34506;
      4'h7: inv_row = 128'hd02c1e8fca3f0f02c1afbd0301138a6b;
      4'h8: inv_row = 128'h3a9111414f67dcea97f2cfcef0b4e673;
      4'h9: inv_row = 128'h96ac7422e7ad3585e2f937e81c75df6e;
      4'ha: inv_row = 128'h47f11a711d29c5896fb7620eaa18be1b;
      4'hb: inv_row = 128'hfc563e4bc6d279209adbc0fe78cd5af4;
      4'hc: inv_row = 128'h1fdda8338807c731b11210592780ec5f;
      4'hd: inv_row = 128'h60517fa919b54a0d2de57a9f93c99cef;
      4'he: inv_row = 128'ha0e03b4dae2af5b0c8ebbb3c83539961;
      default: inv_row = 128'h172b047eba77d626e169146355210c7d;
    endcase
  end
`ifdef INV_SUB_BYTES_FWD_EN
  logic [127:0] fwd_row;
  always_comb begin
    case (a_i[7:4])
      4'h0: fwd_row = 128'h637c777bf26b6fc53001672bfed7ab76;
      4'h1: fwd_row = 128'hca82c97dfa5947f0add4a2af9ca472c0;
      4'h2: fwd_row = 128'hb7fd9326363ff7cc34a5e5f171d83115;
      4'h3: fwd_row = 128'h04c723c31896059a071280e2eb27b275;
      4'h4: fwd_row = 128'h09832c1a1b6e5aa0523bd6b329e32f84;
      4'h5: fwd_row = 128'h53d100ed20fcb15b6acbbe394a4c58cf;
      4'h6: fwd_row = 128'hd0efaafb434d338545f9027f503c9fa8;
      4'h7: fwd_row = 128'h51a3408f929d38f5bcb6da2110fff3d2;
      4'h8: fwd_row = 128'hcd0c13ec5f974417c4a77e3d645d1973;
      4'h9: fwd_row = 128'h60814fdc222a908846eeb814de5e0bdb;
      4'ha: fwd_row = 128'he0323a0a4906245cc2d3ac629195e479;
      4'hb: fwd_row = 128'he7c8376d8dd54ea96c56f4ea657aae08;
      4'hc: fwd_row = 128'hba78252e1ca6b4c6e8dd741f4bbd8b8a;
      4'hd: fwd_row = 128'h703eb5664803f60e613557b986c11d9e;
      4'he: fwd_row = 128'he1f8981169d98e949b1e87e9ce5528df;
      default: fwd_row = 128'h8ca1890dbfe6426841992d0fb054bb16;
    endcase
  end
  assign y_o = fwd_i ? fwd_row[{~a_i[3:0], 3'b000} +: 8] : inv_row[{~a_i[3:0], 3'b000} +: 8];
`else
  assign y_o = inv_row[{~a_i[3:0], 3'b000} +: 8];
`endif
endmodule

// File: rtl/inv_sub_bytes_seq.sv
// inv_sub_bytes_seq: sequential AES InvSubBytes, LANES bytes per cycle; INV_SUB_BYTES_FWD_EN adds a forward-S-box mode
module inv_sub_bytes_seq import aes_pkg::*; #(
  parameter int LANES = 1
) (
  input logic                clk,
  input logic                rst,
  inv_sub_bytes_seq_if.slave bus
);
  localparam int G  = groups(LANES);
  localparam int CW = cnt_w(LANES);
  if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8 || LANES == 16)) begin : g_bad_lanes
    $error("inv_sub_bytes_seq: LANES must be 1, 2, 4, 8 or 16");
  end
  state_e        state_q;
  logic [127:0]  st_q, st_d;
  logic [CW-1:0] cnt_q;
  logic [6:0]    base;
  logic          last;
  byte_t         sb_in  [LANES];
  byte_t         sb_out [LANES];
`ifdef INV_SUB_BYTES_FWD_EN
  logic          mode_q;
`endif
  assign base = 7'(cnt_q) * 7'(LANES * 8);
  assign last = cnt_q == CW'(G - 1);
  assign bus.in_ready  = (state_q == IDLE) && !rst;
  assign bus.out_valid = state_q == DONE;
  assign bus.out_data  = st_q;
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    assign sb_in[i] = st_q[base + 7'(8 * i) +: 8];
    inv_sbox u_sbox (
      .a_i   (sb_in[i]),
`ifdef INV_SUB_BYTES_FWD_EN
      .fwd_i (mode_q),
`endif
      .y_o   (sb_out[i])
    );
  end
  always_comb begin
    st_d = st_q;
    for (int j = 0; j < LANES; j++) st_d[base + 7'(8 * j) +: 8] = sb_out[j];
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      st_q    <= '0;
      cnt_q   <= '0;
`ifdef INV_SUB_BYTES_FWD_EN
      mode_q  <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: if (bus.in_valid) begin
          st_q    <= bus.in_data;
          cnt_q   <= '0;
          state_q <= RUN;
`ifdef INV_SUB_BYTES_FWD_EN
          mode_q  <= bus.mode;
`endif
        end
        RUN: begin
          st_q    <= st_d;
          cnt_q   <= last ? cnt_q : cnt_q + CW'(1);
          state_q <= last ? DONE : RUN;
        end
        DONE: if (bus.out_ready) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_inv_sub_bytes_seq.sv
// tb_inv_sub_bytes_seq: vector table, corner sequences and random blocks against a GF(2^8) S-box model
module tb_inv_sub_bytes_seq;
  logic clk, rst;
  int total, bad;
  logic cur_mode;
  logic [7:0] fwd_tab [256];
  logic [7:0] inv_tab [256];
  typedef struct {
    logic [127:0] din;
    logic         m;
    logic [127:0] exp;
    int           stall;
  } vec_t;
  vec_t vt[$];
  inv_sub_bytes_seq_if bus();
  inv_sub_bytes_seq_if bus4();
  inv_sub_bytes_seq_if bus16();
  inv_sub_bytes_seq #(.LANES(1)) dut (.clk(clk), .rst(rst), .bus(bus));
  inv_sub_bytes_seq #(.LANES(4)) dut4 (.clk(clk), .rst(rst), .bus(bus4));
  inv_sub_bytes_seq #(.LANES(16)) dut16 (.clk(clk), .rst(rst), .bus(bus16));
  initial clk = 1'b0;
  always #5 clk = ~clk;
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, y;
    p = 8'h00; x = a; y = b;
    for (int k = 0; k < 8; k++) begin
      if (y[0]) p = p ^ x;
      x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
      y = y >> 1;
    end
    return p;
  endfunction
  function automatic logic [7:0] rotl(input logic [7:0] v, input int n);
    return (v << n) | (v >> (8 - n));
  endfunction
  function automatic logic [7:0] sbox_calc(input logic [7:0] v);
    logic [7:0] b;
    b = 8'h00;
    for (int y = 1; y < 256; y++) if (v != 8'h00 && gmul(v, 8'(y)) == 8'h01) b = 8'(y);
    return b ^ rotl(b, 1) ^ rotl(b, 2) ^ rotl(b, 3) ^ rotl(b, 4) ^ 8'h63;
  endfunction
  function automatic logic [127:0] model(input logic [127:0] d, input logic m);
    logic [127:0] r;
    for (int k = 0; k < 16; k++) r[8*k +: 8] = m ? fwd_tab[d[8*k +: 8]] : inv_tab[d[8*k +: 8]];
    return r;
  endfunction
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic check(input string nm, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask
  task automatic run_block(input logic [127:0] d, input logic [127:0] exp, input int stall);
    int n;
    bus.in_data   = d;
    bus.in_valid  = 1'b1;
    bus.out_ready = (stall == 0);
`ifdef INV_SUB_BYTES_FWD_EN
    bus.mode = cur_mode;
`endif
    n = 0;
    while (!bus.in_ready && n < 50) begin tick(); n++; end
    check("accept_ready", 128'(bus.in_ready), 128'(1));
    tick();
    bus.in_valid = 1'b0;
    bus.in_data  = ~d;
    check("busy_in_ready", 128'(bus.in_ready), 128'(0));
    n = 0;
    while (!bus.out_valid && n < 40) begin
`ifdef INV_SUB_BYTES_FWD_EN
      bus.mode = ~bus.mode;
`endif
      tick();
      n++;
    end
    check("latency", 128'(n), 128'(16));
    check("result", bus.out_data, exp);
    for (int s = 0; s < stall; s++) begin
      bus.in_valid = (s == 1);
      tick();
      check("stall_valid", 128'(bus.out_valid), 128'(1));
      check("stall_data", bus.out_data, exp);
      check("stall_in_ready", 128'(bus.in_ready), 128'(0));
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    check("drain_valid", 128'(bus.out_valid), 128'(0));
    check("drain_in_ready", 128'(bus.in_ready), 128'(1));
  endtask
  initial begin
    logic [127:0] d, r4, r16;
    int l4, l16;
    total = 0; bad = 0; cur_mode = 1'b0;
    for (int x = 0; x < 256; x++) fwd_tab[x] = sbox_calc(8'(x));
    for (int x = 0; x < 256; x++) inv_tab[fwd_tab[x]] = 8'(x);
    bus.in_valid = 1'b0; bus.in_data = '0; bus.out_ready = 1'b1;
    bus4.in_valid = 1'b0; bus4.in_data = '0; bus4.out_ready = 1'b1;
    bus16.in_valid = 1'b0; bus16.in_data = '0; bus16.out_ready = 1'b1;
`ifdef INV_SUB_BYTES_FWD_EN
    bus.mode = 1'b0; bus4.mode = 1'b0; bus16.mode = 1'b0;
`endif
    rst = 1'b1;
    tick(); tick();
    check("rst_in_ready", 128'(bus.in_ready), 128'(0));
    check("rst_out_valid", 128'(bus.out_valid), 128'(0));
    check("rst_out_data", bus.out_data, 128'(0));
    rst = 1'b0;
    #1;
    check("post_rst_in_ready", 128'(bus.in_ready), 128'(1));
    vt.push_back('{128'h76abd7fe2b670130c56f6bf27b777c63, 1'b0, 128'h0f0e0d0c0b0a09080706050403020100, 0});
    vt.push_back('{{16{8'h63}}, 1'b0, {16{8'h00}}, 0});
    vt.push_back('{{16{8'h00}}, 1'b0, {16{8'h52}}, 0});
    vt.push_back('{{16{8'hed}}, 1'b0, {16{8'h53}}, 5});
`ifdef INV_SUB_BYTES_FWD_EN
    vt.push_back('{{16{8'h00}}, 1'b1, {16{8'h63}}, 0});
    vt.push_back('{{16{8'h00}}, 1'b0, {16{8'h52}}, 2});
    vt.push_back('{{16{8'h53}}, 1'b1, {16{8'hed}}, 1});
`endif
    for (int i = 0; i < vt.size(); i++) begin
      cur_mode = vt[i].m;
      run_block(vt[i].din, vt[i].exp, vt[i].stall);
    end
    // abort a block seven cycles into RUN
    d = {$urandom, $urandom, $urandom, $urandom};
    bus.in_data = d; bus.in_valid = 1'b1; bus.out_ready = 1'b1;
    check("mid_rst_ready", 128'(bus.in_ready), 128'(1));
    tick();
    bus.in_valid = 1'b0;
    repeat (6) tick();
    check("mid_rst_no_partial", 128'(bus.out_valid), 128'(0));
    rst = 1'b1;
    tick();
    check("mid_rst_valid", 128'(bus.out_valid), 128'(0));
    check("mid_rst_data", bus.out_data, 128'(0));
    check("mid_rst_in_ready_low", 128'(bus.in_ready), 128'(0));
    rst = 1'b0;
    #1;
    check("mid_rst_in_ready", 128'(bus.in_ready), 128'(1));
    cur_mode = 1'b0;
    d = {$urandom, $urandom, $urandom, $urandom};
    run_block(d, model(d, 1'b0), 0);
    for (int i = 0; i < 6; i++) begin
      d = {$urandom, $urandom, $urandom, $urandom};
`ifdef INV_SUB_BYTES_FWD_EN
      cur_mode = 1'($urandom_range(0, 1));
`endif
      run_block(d, model(d, cur_mode), $urandom_range(0, 3));
    end
    // wider lane counts run side by side on the same block
    bus4.in_data = {16{8'hed}}; bus16.in_data = {16{8'hed}};
    bus4.in_valid = 1'b1; bus16.in_valid = 1'b1;
    check("l4_in_ready", 128'(bus4.in_ready), 128'(1));
    check("l16_in_ready", 128'(bus16.in_ready), 128'(1));
    tick();
    bus4.in_valid = 1'b0; bus16.in_valid = 1'b0;
    l4 = 0; l16 = 0; r4 = '0; r16 = '0;
    for (int c = 1; c <= 10; c++) begin
      tick();
      if (bus4.out_valid && l4 == 0) begin l4 = c; r4 = bus4.out_data; end
      if (bus16.out_valid && l16 == 0) begin l16 = c; r16 = bus16.out_data; end
    end
    check("l4_latency", 128'(l4), 128'(4));
    check("l16_latency", 128'(l16), 128'(1));
    check("l4_data", r4, {16{8'h53}});
    check("l16_data", r16, {16{8'h53}});
    check("l4_model", r4, model({16{8'hed}}, 1'b0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/inv_sub_bytes_seq.md
Name: inv_sub_bytes_seq

Overview:
Sequential AES InvSubBytes engine for the decrypt datapath. Accepts a 128-bit state over a valid/ready handshake and applies the inverse S-box to all 16 bytes, LANES bytes per cycle. Returns the result over a second valid/ready handshake. Sits between InvShiftRows and AddRoundKey in the iterative AES-128 decrypt core, and mirrors the forward byte S-box used on the encrypt side.

Parameters:
LANES, 1, bytes substituted per cycle; legal values 1, 2, 4, 8, 16; any other value is an elaboration error.

Ports:
clk  input  1  single clock; all state updates on rising edge
rst  input  1  synchronous, active-high reset
in_valid  input  1  upstream state word valid
in_ready  output  1  engine can accept a state word
in_data  input  128  input state; byte i = bits [8i+7:8i]
out_valid  output  1  result valid
out_ready  input  1  downstream accepts result
out_data  output  128  substituted state; same byte ordering as in_data

Behaviour:
- Clocking and reset: one clock (clk); reset (rst) is synchronous and active-high.
- FSM states: IDLE, RUN, DONE.
- Registers: 128-bit state register st; group counter cnt, width clog2(16/LANES), minimum 1 bit.
- Reset values: state IDLE, st = 0, cnt = 0, out_valid = 0, out_data = 0. in_ready is 0 while rst is high and 1 in the first cycle after release.
- in_ready = (state == IDLE) && !rst.
- out_valid = (state == DONE).
- out_data = st in all states.
- IDLE:
  - If in_valid && in_ready: st <= in_data, cnt <= 0, go to RUN.
  - Otherwise hold.
- RUN: each cycle, bytes cnt*LANES .. cnt*LANES+LANES-1 of st are replaced by inv_sbox(byte); cnt increments.
  - When cnt == 16/LANES-1, the final group is written and the FSM goes to DONE.
  - Processing order is byte 0 upward.
- DONE: hold st.
  - If out_ready, go to IDLE.
  - out_data must stay stable while out_valid && !out_ready.
- Latency: acceptance at edge k, so out_valid is visible after edge k + 16/LANES.
  - LANES=1: 16 cycles; LANES=16: 1 cycle.
- Throughput: with out_ready tied high, one block per 16/LANES + 2 cycles. There is no accept in the same cycle as result drain.
- in_valid while busy: ignored, because in_ready is low. The upstream holds the data.
- out_ready while not DONE: ignored.
- Reset mid-operation (RUN or DONE): the block is discarded, every register returns to its reset value on that edge, and no partial result is ever presented.
- cnt does not wrap within a block; it is reloaded to 0 on acceptance.

Optional Feature:
Macro INV_SUB_BYTES_FWD_EN.
- Defined:
  - Adds input port mode (1 bit), sampled with in_data on acceptance and held for the whole block.
  - mode=0 applies the inverse S-box; mode=1 applies the forward S-box.
  - Encrypt and decrypt then share one engine.
- Undefined:
  - No mode port; inverse S-box only.
  - No forward-table logic is synthesized.

Decomposition:
- Package aes_pkg:
  - AES_NUM_BYTES = 16 and the byte_t (8-bit) typedef.
  - State enum IDLE/RUN/DONE.
  - Function or localparam for groups = AES_NUM_BYTES/LANES.
- Sub-module inv_sbox:
  - Combinational 8->8 inverse S-box, written as a constant case table.
  - No file loading, no absolute paths.
  - Instantiated LANES times.
  - Under INV_SUB_BYTES_FWD_EN, a forward table plus a mux per lane.

Test Plan:
- LANES=1: reset, then in_data = 128'h76abd7fe2b670130c56f6bf27b777c63 with in_valid -> out_valid exactly 16 cycles after acceptance, out_data = 128'h0f0e0d0c0b0a09080706050403020100.
- All bytes 0x63, then a second block with all bytes 0x00 -> results all 0x00, then all 0x52. in_ready is low from acceptance until the result is drained.
- Backpressure: out_ready low for 5 cycles after out_valid -> out_valid and out_data held constant; in_ready stays 0; a pulsed in_valid is not accepted; the result drains on the first out_ready=1 cycle.
- Reset mid-RUN (cycle 7 of 16) -> the following cycle out_valid=0, out_data=0, in_ready=1; a new block then completes correctly in 16 cycles.
- LANES=4 and LANES=16: all bytes 0xED -> all bytes 0x53 after 4 and 1 cycles respectively.
- INV_SUB_BYTES_FWD_EN defined:
  - mode=1, all bytes 0x00 -> all 0x63.
  - mode=0, same input -> all 0x52.
  - Toggling mode during RUN has no effect.
